led7capture: RTL and testbench



---
 rtl/led7_pkg.sv | 18 +
 rtl/led7capture_if.sv | 22 ++
 rtl/led7deconv.sv | 23 ++
 rtl/led7capture.sv | 138 +++++++++++++
 tb/tb_led7capture.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/led7_pkg.sv
// Shared definitions for the 7-segment encoder/decoder pair: active-low
// glyph table, blank pattern and the capture FSM state type.
package led7_pkg;

    typedef enum logic {
        S_SETTLE,
        S_HELD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index i holds the {g,f,e,d,c,b,a} active-low pattern for hex digit i.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/led7capture_if.sv
// Display bus seen by the capture block: pins in, decoded word out.
// master = display side / checker, slave = led7capture.
interface led7capture_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   i_w_an;
    logic [7:0]          i_w_seg;
    logic [4*DIGITS-1:0] o_w_value;
    logic [DIGITS-1:0]   o_w_dp;
    logic                o_w_valid;
    logic                o_w_err;

    modport master (
        output i_w_an, i_w_seg,
        input  o_w_value, o_w_dp, o_w_valid, o_w_err
    );

    modport slave (
        input  i_w_an, i_w_seg,
        output o_w_value, o_w_dp, o_w_valid, o_w_err
    );
endinterface

// File: rtl/led7deconv.sv
// Inverse hex glyph lookup: 7-bit active-low pattern -> nibble plus hit flag.
module led7deconv
    import led7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       hit
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led7capture.sv
// Multiplexed active-low 7-segment bus reader; emits the full decoded word
// once every digit has been captured. Define LED7CAPTURE_DP_EN to capture dp.
module led7capture
    import led7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic          i_w_clk,
    input  logic          i_w_reset,
    led7capture_if.slave  bus
);

    localparam int PW = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES);

`ifdef LED7CAPTURE_DP_EN
    localparam logic [PW-1:0] CMP_MASK = '1;
`else
    localparam logic [PW-1:0] CMP_MASK = {{DIGITS{1'b1}}, 1'b0, 7'h7F};
`endif

    logic [PW-1:0]       samp;
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   mask;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_q;
    logic                valid;
    logic                err;

    logic [PW-1:0]       pins;
    logic                changed;
    logic                sample_fire;
    logic                frame_full;
    logic [DIGITS-1:0]   an_low;
    logic                dp_bit;
    logic [3:0]          dec_nibble;
    logic                dec_hit;

    logic [DIGITS-1:0]   mask_nx;
    logic [4*DIGITS-1:0] shadow_val_nx;
    logic [DIGITS-1:0]   shadow_dp_nx;
    logic                err_nx;

    // Comparing the incoming pins with the register makes the sample event
    // land on the edge that registers the pattern for the STABLE_CYCLES-th time.
    assign pins        = {bus.i_w_an, bus.i_w_seg};
    assign changed     = ((pins ^ samp) & CMP_MASK) != '0;
    assign sample_fire = (state == S_SETTLE) && !changed
                         && (cnt == CW'(STABLE_CYCLES - 2));
    assign frame_full  = &mask;
    assign an_low      = ~samp[PW-1:8];

`ifdef LED7CAPTURE_DP_EN
    assign dp_bit = ~samp[7];
`else
    assign dp_bit = 1'b0;
`endif

    led7deconv u_deconv (
        .pattern (samp[6:0]),
        .nibble  (dec_nibble),
        .hit     (dec_hit)
    );

    // A sample event lands on the mask after any frame-complete clear.
    always_comb begin
        mask_nx       = frame_full ? '0 : mask;
        shadow_val_nx = shadow_val;
        shadow_dp_nx  = shadow_dp;
        err_nx        = 1'b0;
        if (sample_fire && (an_low != '0)) begin
            if (!$onehot(an_low)) begin
                err_nx = 1'b1;
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (an_low[k]) begin
                        if (dec_hit) begin
                            shadow_val_nx[4*k +: 4] = dec_nibble;
                            shadow_dp_nx[k]         = dp_bit;
                            mask_nx[k]              = 1'b1;
                        end else begin
                            err_nx     = 1'b1;
                            mask_nx[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            samp       <= '1;
            state      <= S_SETTLE;
            cnt        <= '0;
            mask       <= '0;
            // NOTE: the shadow word is reset too, so a partial frame can never
            // resurface in a word assembled after reset.
            shadow_val <= '0;
            shadow_dp  <= '0;
            value      <= '0;
            dp_q       <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here, so every register
            // samples the pre-edge values regardless of statement order.
            samp <= pins;
            if (changed) begin
                state <= S_SETTLE;
                cnt   <= '0;
            end else if (state == S_SETTLE) begin
                cnt <= cnt + CW'(1);
                if (sample_fire) state <= S_HELD;
            end

            mask       <= mask_nx;
            shadow_val <= shadow_val_nx;
            shadow_dp  <= shadow_dp_nx;
            err        <= err_nx;
            valid      <= frame_full;
            if (frame_full) begin
                value <= shadow_val;
                dp_q  <= shadow_dp;
            end
        end
    end

    assign bus.o_w_value = value;
    assign bus.o_w_dp    = dp_q;
    assign bus.o_w_valid = valid;
    assign bus.o_w_err   = err;

endmodule

// File: tb/tb_led7capture.sv
// Self-checking bench for led7capture (DIGITS=4, STABLE_CYCLES=4): table-driven
// scans, hand-written reset sequences and a random run against a run-length model.
module tb_led7capture;

    localparam int DIGITS = 4;
    localparam int S      = 4;

`ifdef LED7CAPTURE_DP_EN
    localparam logic [11:0] PMASK  = 12'hFFF;
    localparam logic [3:0]  DP_EXP = 4'b0010;
`else
    localparam logic [11:0] PMASK  = 12'hF7F;
    localparam logic [3:0]  DP_EXP = 4'b0000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an_drv = 4'hF;
    logic [7:0] seg_drv = 8'hFF;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [6:0] hex_pat [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    led7capture_if #(.DIGITS(DIGITS)) bus ();
    assign bus.i_w_an  = an_drv;
    assign bus.i_w_seg = seg_drv;

    led7capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pattern is sampled when it has been seen on exactly
    // S consecutive edges; the word is published the edge after all digits are in.
    logic [11:0] m_last;
    int          m_run;
    logic [3:0]  m_mask;
    logic [15:0] m_shadow, m_value;
    logic [3:0]  m_sdp, m_dp;
    logic        m_valid, m_err;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (hex_pat[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [11:0] p;
        logic [3:0]  low;
        int          k, nib;
        p = {an_drv, seg_drv} & PMASK;
        if (rst) begin
            m_last = 12'hFFF & PMASK; m_run = 1; m_mask = '0;
            m_shadow = '0; m_sdp = '0; m_value = '0; m_dp = '0;
            m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (p == m_last) begin
                if (m_run <= S) m_run++;
            end else begin
                m_last = p; m_run = 1;
            end
            m_err = 1'b0;
            m_valid = (m_mask == 4'hF);
            if (m_valid) begin
                m_value = m_shadow; m_dp = m_sdp; m_mask = '0;
            end
            if (m_run == S) begin
                low = ~an_drv;
                if ($countones(low) > 1) m_err = 1'b1;
                else if ($countones(low) == 1) begin
                    k = 0;
                    for (int i = 0; i < 4; i++) if (low[i]) k = i;
                    nib = decode(seg_drv[6:0]);
                    if (nib >= 0) begin
                        m_shadow[4*k +: 4] = 4'(nib);
                        m_sdp[k] = (PMASK[7] == 1'b1) ? ~seg_drv[7] : 1'b0;
                        m_mask[k] = 1'b1;
                    end else begin
                        m_err = 1'b1; m_mask[k] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model", {bus.o_w_valid, bus.o_w_err, bus.o_w_dp, bus.o_w_value},
                  {m_valid, m_err, m_dp, m_value});
    end

    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int hold,
                         output int nv, output int ne);
        an_drv = an; seg_drv = seg; nv = 0; ne = 0;
        repeat (hold) begin
            @(negedge clk);
            if (bus.o_w_valid) nv++;
            if (bus.o_w_err) ne++;
        end
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          hold;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_value;
        logic [3:0]  exp_dp;
    } step_t;

    step_t steps [19];

    initial begin
        int nv, ne, tv, te, r;
        logic [3:0] an;
        logic [7:0] seg;

        steps[0]  = '{4'b0111, 8'hF9, 8, 0, 0, 16'h0000, 4'h0};
        steps[1]  = '{4'b1011, 8'hA4, 8, 0, 0, 16'h0000, 4'h0};
        steps[2]  = '{4'b1101, 8'hB0, 8, 0, 0, 16'h0000, 4'h0};
        steps[3]  = '{4'b1110, 8'h99, 8, 1, 0, 16'h1234, 4'h0};
        steps[4]  = '{4'b0111, 8'h92, 8, 0, 0, 16'h1234, 4'h0};
        steps[5]  = '{4'b1011, 8'h82, 3, 0, 0, 16'h1234, 4'h0};
        steps[6]  = '{4'b1101, 8'hF8, 8, 0, 0, 16'h1234, 4'h0};
        steps[7]  = '{4'b1110, 8'h80, 8, 0, 0, 16'h1234, 4'h0};
        steps[8]  = '{4'b1011, 8'h82, 8, 1, 0, 16'h5678, 4'h0};
        steps[9]  = '{4'b0111, 8'hF9, 8, 0, 0, 16'h5678, 4'h0};
        steps[10] = '{4'b1011, 8'hA4, 8, 0, 0, 16'h5678, 4'h0};
        steps[11] = '{4'b1101, 8'hFF, 8, 0, 1, 16'h5678, 4'h0};
        steps[12] = '{4'b1110, 8'h99, 8, 0, 0, 16'h5678, 4'h0};
        steps[13] = '{4'b1101, 8'h30, 8, 1, 0, 16'h1234, DP_EXP};
        steps[14] = '{4'b0111, 8'h99, 8, 0, 0, 16'h1234, DP_EXP};
        steps[15] = '{4'b1011, 8'hB0, 8, 0, 0, 16'h1234, DP_EXP};
        steps[16] = '{4'b0011, 8'hF9, 8, 0, 1, 16'h1234, DP_EXP};
        steps[17] = '{4'b1101, 8'hA4, 8, 0, 0, 16'h1234, DP_EXP};
        steps[18] = '{4'b1110, 8'hF9, 8, 1, 0, 16'h4321, 4'h0};

        // Reset held three cycles with random pins.
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) begin
            an_drv = 4'($urandom); seg_drv = 8'($urandom);
            @(negedge clk);
        end
        check("reset_outputs", {bus.o_w_valid, bus.o_w_err, bus.o_w_dp, bus.o_w_value}, 0);
        rst = 1'b0;
        apply(4'hF, 8'hFF, 10, nv, ne);
        check("idle_valid", nv, 0);
        check("idle_err", ne, 0);

        foreach (steps[i]) begin
            apply(steps[i].an, steps[i].seg, steps[i].hold, nv, ne);
            check($sformatf("step%0d_valid", i), nv, steps[i].exp_valid);
            check($sformatf("step%0d_err", i), ne, steps[i].exp_err);
            check($sformatf("step%0d_word", i), {bus.o_w_dp, bus.o_w_value},
                  {steps[i].exp_dp, steps[i].exp_value});
        end

        // Reset after three captured digits discards the partial frame.
        apply(4'b0111, 8'hF9, 8, nv, ne); tv = nv;
        apply(4'b1011, 8'hA4, 8, nv, ne); tv += nv;
        apply(4'b1101, 8'hB0, 8, nv, ne); tv += nv;
        check("partial_valid", tv, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_word", {bus.o_w_valid, bus.o_w_dp, bus.o_w_value}, 0);
        apply(4'b1110, 8'h99, 8, nv, ne);
        check("after_reset_one_digit", nv, 0);
        apply(4'b0111, 8'h90, 8, nv, ne); tv = nv;
        apply(4'b1011, 8'h88, 8, nv, ne); tv += nv;
        check("after_reset_three_digits", tv, 0);
        apply(4'b1101, 8'h83, 8, nv, ne);
        check("after_reset_full_valid", nv, 1);
        check("after_reset_full_word", {bus.o_w_dp, bus.o_w_value}, {4'h0, 16'h9AB4});

        // Random traffic, checked cycle by cycle against the model.
        an = 4'b1110; seg = 8'hC0;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 22) begin
                seg[7] = ~seg[7];
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 10) an = 4'hF;
                else if (r < 25) an = 4'($urandom);
                else an = ~(4'b0001 << $urandom_range(0, 3));
                if ($urandom_range(0, 99) < 80)
                    seg = {1'($urandom), hex_pat[$urandom_range(0, 15)]};
                else
                    seg = 8'($urandom);
            end
            apply(an, seg, int'($urandom_range(1, 10)), nv, ne);
            te = ne;
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
